// File: rtl/spart_rx.sv
// ----------------------------------------------------------------------------
// spart_rx
//   Asynchronous serial receiver for the mini SPART. It decodes 8N1 frames
//   (LSB first, idle high) from RxD using the same OVERSAMPLE-per-bit baud
//   enable as the transmitter. Each completed frame is handed to the bus side
//   as one held byte, together with a read-data-available flag.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   en         in   baud enable, OVERSAMPLE one-clk pulses per bit time
//   RxD        in   asynchronous serial input
//   clr_rda    in   bus read strobe; consumes the held byte
//   rx_data    out  last accepted byte
//   rda        out  received data available
//   frame_err  out  stop bit of the last accepted byte was sampled low
//   overrun    out  a byte completed while rda was still set (byte dropped)
//
// Parameters
//   DATA_BITS   payload bits per frame
//   OVERSAMPLE  en ticks per bit; a power of two and >= 4
// ----------------------------------------------------------------------------
module spart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 RxD,
    input  logic                 clr_rda,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Tick that lands mid start bit, and the tick one full bit later which
    // therefore lands mid every following bit.
    localparam logic [SW-1:0] MID_CNT  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] LAST_CNT = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q;
    logic                   rxs_q;
    logic [SW-1:0]          sample_q, sample_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   rda_q, rda_d;
    logic                   fe_q, fe_d;
    logic                   ovr_q, ovr_d;
    logic                   complete;

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        data_d   = data_q;
        rda_d    = rda_q;
        fe_d     = fe_q;
        ovr_d    = ovr_q;
        complete = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en && !rxs_q) begin
                    state_d  = S_START;
                    sample_d = '0;
                end
            end

            S_START: begin
                if (en) begin
                    if (sample_q == MID_CNT) begin
                        // Re-check the line mid start bit; a short low
                        // pulse is dropped silently.
                        if (!rxs_q) begin
                            state_d  = S_DATA;
                            sample_d = '0;
                            bit_d    = '0;
                        end else begin
                            state_d  = S_IDLE;
                        end
                    end else begin
                        sample_d = sample_q + 1'b1;
                    end
                end
            end

            S_DATA: begin
                if (en) begin
                    // Counter wraps to 0 after LAST_CNT, starting the next bit.
                    sample_d = sample_q + 1'b1;
                    if (sample_q == LAST_CNT) begin
                        // Right shift: first bit received ends up in bit 0.
                        shift_d[DATA_BITS-1] = rxs_q;
                        for (int i = 0; i < DATA_BITS - 1; i++)
                            shift_d[i] = shift_q[i+1];
                        if (bit_q == LAST_BIT)
                            state_d = S_STOP;
                        else
                            bit_d = bit_q + 1'b1;
                    end
                end
            end

            S_STOP: begin
                if (en) begin
                    sample_d = sample_q + 1'b1;
                    if (sample_q == LAST_CNT) begin
                        complete = 1'b1;
                        // A low stop bit may be a break; wait for the line to
                        // go high before arming for a new start bit.
                        state_d  = rxs_q ? S_IDLE : S_BREAK;
                    end
                end
            end

            S_BREAK: begin
                if (en && rxs_q)
                    state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // Bus-side holding register. A completing byte is accepted if the
        // holder is empty or is being read in this very cycle; otherwise it
        // is dropped and flagged.
        if (complete) begin
            if (!rda_q || clr_rda) begin
                data_d = shift_q;
                rda_d  = 1'b1;
                fe_d   = ~rxs_q;
                if (clr_rda)
                    ovr_d = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (clr_rda) begin
            rda_d = 1'b0;
            ovr_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sync1_q  <= 1'b1;
            rxs_q    <= 1'b1;
            sample_q <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            rda_q    <= 1'b0;
            fe_q     <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= RxD;
            rxs_q    <= sync1_q;
            sample_q <= sample_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            rda_q    <= rda_d;
            fe_q     <= fe_d;
            ovr_q    <= ovr_d;
        end
    end

    assign rx_data   = data_q;
    assign rda       = rda_q;
    assign frame_err = fe_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_spart_rx.sv
// ----------------------------------------------------------------------------
// tb_spart_rx
//   Self-checking bench for spart_rx. Frames are driven bit-by-bit on RxD in
//   units of baud ticks; a small model of the bus-visible holding register
//   (data, rda, frame_err, overrun) predicts the outputs after each frame or
//   read strobe.
// ----------------------------------------------------------------------------
module tb_spart_rx;

    localparam int EN_DIV = 4;
    localparam int OS     = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       RxD = 1'b1;
    logic       clr_rda = 1'b0;
    logic [7:0] rx_data;
    logic       rda, frame_err, overrun;

    int tests = 0;
    int fails = 0;
    int div   = 0;

    // reference model of the bus-visible state
    logic [7:0]  m_data;
    logic        m_rda, m_fe, m_ovr;
    logic [10:0] obs, exp_v;

    spart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .RxD       (RxD),
        .clr_rda   (clr_rda),
        .rx_data   (rx_data),
        .rda       (rda),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // one-clk baud enable every EN_DIV clocks
    always @(posedge clk) begin
        #1;
        div = (div == EN_DIV - 1) ? 0 : div + 1;
        en  = (div == EN_DIV - 1);
    end

    // returns 2 time units after the n-th en-qualified clock edge
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (en !== 1'b1);
        end
        #2;
    endtask

    // start bit, LSB-first payload, stop bit; line is left at the stop level
    task automatic send_frame(input logic [7:0] b, input logic stopb);
        RxD = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            wait_ticks(OS);
        end
        RxD = stopb;
        wait_ticks(OS);
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stopb);
        if (!m_rda) begin
            m_data = b;
            m_rda  = 1'b1;
            m_fe   = ~stopb;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_data = 8'h00; m_rda = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_rda = 1'b1;
        @(posedge clk);
        #2 clr_rda = 1'b0;
        m_rda = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; RxD = 1'b1; clr_rda = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        obs = {rda, overrun, frame_err, rx_data}; exp_v = {m_rda, m_ovr, m_fe, m_data};
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL reset: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_basic();
        wait_ticks(2);
        send_frame(8'hA5, 1'b1);
        model_frame(8'hA5, 1'b1);
        obs = {rda, overrun, frame_err, rx_data}; exp_v = {m_rda, m_ovr, m_fe, m_data};
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL basic_A5: got %h want %h", obs, exp_v); end
        pulse_clr();
        obs = {rda, overrun, frame_err, rx_data}; exp_v = {m_rda, m_ovr, m_fe, m_data};
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL basic_clr: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_glitch();
        RxD = 1'b0;
        wait_ticks(4);
        RxD = 1'b1;
        wait_ticks(2 * OS);
        obs = {rda, overrun, frame_err, rx_data}; exp_v = {m_rda, m_ovr, m_fe, m_data};
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL glitch_ignored: got %h want %h", obs, exp_v); end
        send_frame(8'h5A, 1'b1);
        model_frame(8'h5A, 1'b1);
        obs = {rda, overrun, frame_err, rx_data}; exp_v = {m_rda, m_ovr, m_fe, m_data};
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL glitch_next_frame: got %h want %h", obs, exp_v); end
        pulse_clr();
    endtask

    task automatic test_break();
        send_frame(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0);
        wait_ticks(2 * OS);   // line held low past the stop bit
        obs = {rda, overrun, frame_err, rx_data}; exp_v = {m_rda, m_ovr, m_fe, m_data};
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL break_3C: got %h want %h", obs, exp_v); end
        RxD = 1'b1;
        wait_ticks(OS);
        // a re-armed low line would have produced another byte -> overrun
        obs = {rda, overrun, frame_err, rx_data}; exp_v = {m_rda, m_ovr, m_fe, m_data};
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL break_no_rearm: got %h want %h", obs, exp_v); end
        pulse_clr();
        send_frame(8'h55, 1'b1);
        model_frame(8'h55, 1'b1);
        obs = {rda, overrun, frame_err, rx_data}; exp_v = {m_rda, m_ovr, m_fe, m_data};
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL break_then_55: got %h want %h", obs, exp_v); end
        pulse_clr();
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        model_frame(8'h22, 1'b1);
        obs = {rda, overrun, frame_err, rx_data}; exp_v = {m_rda, m_ovr, m_fe, m_data};
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL overrun_set: got %h want %h", obs, exp_v); end
        pulse_clr();
        obs = {rda, overrun, frame_err, rx_data}; exp_v = {m_rda, m_ovr, m_fe, m_data};
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL overrun_clr: got %h want %h", obs, exp_v); end
    endtask

    // clr_rda lands on the stop-sample tick (tick 153 counted from the tick
    // before the start edge: detect at 1, mid-start at 9, stop at 9+16*9)
    task automatic test_same_cycle();
        logic dropped;
        send_frame(8'h42, 1'b1);
        model_frame(8'h42, 1'b1);
        dropped = 1'b0;
        fork
            send_frame(8'h7E, 1'b1);
            begin
                wait_ticks(152);
                repeat (EN_DIV - 1) @(posedge clk);
                #2 clr_rda = 1'b1;
                @(posedge clk);
                #2 clr_rda = 1'b0;
            end
            begin
                repeat (155 * EN_DIV) begin
                    @(negedge clk);
                    if (rda !== 1'b1) dropped = 1'b1;
                end
            end
        join
        m_data = 8'h7E; m_rda = 1'b1; m_fe = 1'b0; m_ovr = 1'b0;
        tests++;
        if (dropped !== 1'b0) begin fails++; $display("FAIL same_cycle_rda_held: got %b want 0", dropped); end
        obs = {rda, overrun, frame_err, rx_data}; exp_v = {m_rda, m_ovr, m_fe, m_data};
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL same_cycle_7E: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_reset_mid();
        RxD = 1'b0;
        wait_ticks(OS);
        RxD = 1'b1;           // payload bits of 0xFF
        wait_ticks(4 * OS);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        obs = {rda, overrun, frame_err, rx_data}; exp_v = {m_rda, m_ovr, m_fe, m_data};
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL reset_mid_zero: got %h want %h", obs, exp_v); end
        wait_ticks(5 * OS);   // rest of 0xFF and its stop bit
        obs = {rda, overrun, frame_err, rx_data}; exp_v = {m_rda, m_ovr, m_fe, m_data};
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL reset_mid_no_partial: got %h want %h", obs, exp_v); end
        send_frame(8'h81, 1'b1);
        model_frame(8'h81, 1'b1);
        obs = {rda, overrun, frame_err, rx_data}; exp_v = {m_rda, m_ovr, m_fe, m_data};
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL reset_mid_81: got %h want %h", obs, exp_v); end
        pulse_clr();
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       s;
        for (int it = 0; it < 10; it++) begin
            b = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            send_frame(b, s);
            model_frame(b, s);
            if (!s) begin
                RxD = 1'b1;
                wait_ticks($urandom_range(OS, OS + 8));
            end
            obs = {rda, overrun, frame_err, rx_data}; exp_v = {m_rda, m_ovr, m_fe, m_data};
            tests++;
            if (obs !== exp_v) begin fails++; $display("FAIL random_frame[%0d]: got %h want %h", it, obs, exp_v); end
            if ($urandom_range(0, 1) == 1) begin
                pulse_clr();
                obs = {rda, overrun, frame_err, rx_data}; exp_v = {m_rda, m_ovr, m_fe, m_data};
                tests++;
                if (obs !== exp_v) begin fails++; $display("FAIL random_clr[%0d]: got %h want %h", it, obs, exp_v); end
            end
            RxD = 1'b1;
            wait_ticks($urandom_range(1, 20));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_overrun();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
